char_classifier: RTL and testbench
==================================

// Module: char_classifier
// PURPOSE
//  Parametrised fixed-point linear classifier: for each of N_CLASSES, computes
//  score = sum(pix[p]*w[c][p]) + bias[c] over N_PIXELS unsigned 8-bit pixels.
//  Outputs the argmax class as ans.
//  Reads the image RAM and the weight RAM (both 1-cycle registered-read).
//  Sits between the picture/weight block RAMs and the result display logic.
// PARAMETERS
//  N_PIXELS  784  pixels per image (image RAM depth)
//  N_CLASSES 10   classes; weight RAM depth = N_CLASSES*(N_PIXELS+1)
//  WEIGHT_W  16   signed weight/bias width (two's complement)
//  ACC_W     32   signed accumulator / score width; must be >= WEIGHT_W+9
//  Derived: PIX_AW=$clog2(N_PIXELS), WGT_AW=$clog2(N_CLASSES*(N_PIXELS+1)), CLS_W=$clog2(N_CLASSES)
// PORTS
//  clk       in  1        single clock, all logic on posedge
//  rst       in  1        synchronous, active-high reset
//  start     in  1        1-cycle request; sampled only in IDLE
//  busy      out 1        high from the cycle after start is accepted until done
//  pix_addr  out PIX_AW   image RAM address
//  pix_data  in  8        image RAM data, valid 1 cycle after pix_addr
//  wgt_addr  out WGT_AW   weight RAM address = c*(N_PIXELS+1)+p; p=N_PIXELS is bias
//  wgt_data  in  WEIGHT_W weight RAM data, valid 1 cycle after wgt_addr
//  done      out 1        1-cycle pulse; ans/score valid and held until next start
//  ans       out CLS_W    winning class index
//  score     out ACC_W    winning class score
// BEHAVIOUR
//  Clock and reset: clk and rst are the only clock and reset; rst is synchronous, active-high.
//  Reset values: busy=0, done=0, ans=0, score=0, pix_addr=0, wgt_addr=0.
//    FSM returns to IDLE; acc and best are cleared.
//  FSM states: IDLE -> ISSUE -> DRAIN -> CMP -> (ISSUE for next class | DONE) -> IDLE.
//  ISSUE: N_PIXELS+1 cycles, one address per cycle, p = 0..N_PIXELS.
//    For p = N_PIXELS, pixel operand is forced to 1 (bias term); pix_addr holds at N_PIXELS-1.
//  Pipeline: address -> RAM data (+1) -> registered product (+2) -> accumulate (+3).
//    DRAIN = 3 cycles flushing this pipeline.
//    acc is cleared at the start of each class.
//  Arithmetic: product = signed(WEIGHT_W+9) {1'b0,pix} * sign-extended wgt.
//    Product is sign-extended to ACC_W before accumulation.
//  CMP (1 cycle):
//    class 0 always loads best.
//    A later class replaces best only if its score is strictly greater (signed compare).
//    Ties therefore keep the lowest index.
//  Per-class cost: N_PIXELS+5 cycles.
//  done asserts exactly N_CLASSES*(N_PIXELS+5)+1 cycles after the clk edge that accepted start.
//  ans/score update in the same cycle done rises.
//  start while busy: ignored, with no effect on the current run.
//  start in the same cycle as done: ignored; the next accept is from IDLE.
//  rst mid-run: abort immediately, all outputs return to reset values, no done pulse.
//  Classes are not overlapped; there is no back-pressure on the RAMs.
// CONFIGURATION
//  ACC_SATURATE_EN defined: accumulator add saturates.
//    Limits are 2^(ACC_W-1)-1 and -2^(ACC_W-1).
//    Bias add saturates too; there is no wrap.
//  ACC_SATURATE_EN undefined: plain two's-complement wrap at ACC_W bits.
// STRUCTURE
//  Package char_reg_pkg holds the FSM state enum (IDLE, ISSUE, DRAIN, CMP, DONE).
//    It also holds the PIPE_LAT=3 constant and the sat_add function used under ACC_SATURATE_EN.
//  Sub-module mac_unit holds the multiply register, the accumulator and the saturation.
//    Ports: clk, rst, clr, en, pix, wgt, acc.
//  Top level keeps the FSM, address counters and argmax.
// TESTING  (N_PIXELS=4, N_CLASSES=3, WEIGHT_W=16, ACC_W=32 unless noted)
//  Basic argmax:
//    Stimulus: pix={1,2,3,4}; class0 w={1,1,1,1} b=0; class1 w={0,0,0,1} b=5; class2 w={-1,-1,-1,-1} b=0.
//    Expected: done at cycle 28 with ans=0, score=10.
//  Tie:
//    Stimulus: class0 and class1 both score 7, class2 scores 3.
//    Expected: ans=0, score=7.
//  All-negative:
//    Stimulus: scores {-20,-3,-9}.
//    Expected: ans=1, score=-3 (proves best is not seeded with 0).
//  Saturation, with WEIGHT_W=8, ACC_W=16:
//    Stimulus: pix all 255, class0 w all 127, b=0.
//    Expected with ACC_SATURATE_EN: class0 score=32767.
//    Expected without ACC_SATURATE_EN: class0 score=-1532 (129540 wrapped).
//  Reset mid-run:
//    Stimulus: rst for 1 cycle at cycle 12.
//    Expected: no done; busy=0 the next cycle; a new start then gives the full result at +28.
//  Start while busy:
//    Stimulus: extra start pulses at cycles 5 and 27.
//    Expected: a single done at cycle 28, ans unchanged, and no second run.

Source files
------------

// File: rtl/char_reg_pkg.sv
// Shared types and helpers for the char_classifier linear classifier.
// ACC_SATURATE_EN selects the saturating accumulator helper below.
package char_reg_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CMP, DONE} state_e;

  // address -> RAM data -> product register -> accumulator
  localparam int PIPE_LAT = 3;

  // Signed add clamped to a w-bit two's-complement range (w <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate stage: registered pixel*weight product, then accumulate.
// ACC_SATURATE_EN makes the accumulate clamp instead of wrap.
module mac_unit
  import char_reg_pkg::*;
#(
  parameter int WEIGHT_W = 16,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [7:0]          pix,
  input  logic [WEIGHT_W-1:0] wgt,
  output logic [ACC_W-1:0]    acc
);
  localparam int PROD_W = WEIGHT_W + 9;

  logic signed [8:0]        pix_s;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d, addend;

  assign pix_s  = {1'b0, pix};
  assign addend = ACC_W'(prod_q);

`ifdef ACC_SATURATE_EN
  assign acc_d = ACC_W'(sat_add(64'(acc_q), 64'(addend), ACC_W));
`else
  assign acc_d = acc_q + addend;
`endif

  // Product loads every cycle; en marks when it holds a real term.
  always_ff @(posedge clk) begin
    if (rst) prod_q <= '0;
    else     prod_q <= PROD_W'(pix_s) * PROD_W'($signed(wgt));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) acc_q <= '0;
    else if (en)    acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/char_classifier.sv
// Linear classifier: per-class dot product plus bias over image/weight RAMs, argmax out.
// Build with ACC_SATURATE_EN for a saturating accumulator (default wraps).
module char_classifier
  import char_reg_pkg::*;
#(
  parameter int N_PIXELS  = 784,
  parameter int N_CLASSES = 10,
  parameter int WEIGHT_W  = 16,
  parameter int ACC_W     = 32,
  localparam int PIX_AW   = $clog2(N_PIXELS),
  localparam int WGT_AW   = $clog2(N_CLASSES*(N_PIXELS+1)),
  localparam int CLS_W    = $clog2(N_CLASSES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic [PIX_AW-1:0]   pix_addr,
  input  logic [7:0]          pix_data,
  output logic [WGT_AW-1:0]   wgt_addr,
  input  logic [WEIGHT_W-1:0] wgt_data,
  output logic                done,
  output logic [CLS_W-1:0]    ans,
  output logic [ACC_W-1:0]    score
);
  localparam int P_W  = $clog2(N_PIXELS+1);
  localparam int DR_W = $clog2(PIPE_LAT);

  state_e                  state_q;
  logic                    busy_q, done_q, bias_q;
  logic [1:0]              vld_pipe_q;
  logic [DR_W-1:0]         drain_q;
  logic [P_W-1:0]          p_q;
  logic [PIX_AW-1:0]       pix_addr_q;
  logic [WGT_AW-1:0]       wgt_addr_q;
  logic [CLS_W-1:0]        cls_q, best_cls_q, ans_q;
  logic signed [ACC_W-1:0] best_q;
  logic [ACC_W-1:0]        score_q, acc;
  logic                    accept, clr;
  logic [7:0]              pix_op;

  // start coinciding with the done pulse is dropped
  assign accept = (state_q == IDLE) && start && !done_q;
  assign clr    = accept || (state_q == CMP);
  assign pix_op = bias_q ? 8'd1 : pix_data;

  mac_unit #(.WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (vld_pipe_q[1]),
    .pix (pix_op),
    .wgt (wgt_data),
    .acc (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bias_q     <= 1'b0;
      vld_pipe_q <= '0;
      drain_q    <= '0;
      p_q        <= '0;
      pix_addr_q <= '0;
      wgt_addr_q <= '0;
      cls_q      <= '0;
      best_cls_q <= '0;
      best_q     <= '0;
      ans_q      <= '0;
      score_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      vld_pipe_q <= {vld_pipe_q[0], state_q == ISSUE};
      bias_q     <= (state_q == ISSUE) && (p_q == P_W'(N_PIXELS));
      case (state_q)
        IDLE: if (accept) begin
          state_q    <= ISSUE;
          busy_q     <= 1'b1;
          cls_q      <= '0;
          p_q        <= '0;
          pix_addr_q <= '0;
          wgt_addr_q <= '0;
        end
        ISSUE: if (p_q == P_W'(N_PIXELS)) begin
          state_q <= DRAIN;
          drain_q <= '0;
        end else begin
          // the bias slot reuses the last pixel address
          p_q        <= p_q + P_W'(1);
          wgt_addr_q <= wgt_addr_q + WGT_AW'(1);
          if (p_q < P_W'(N_PIXELS-1)) pix_addr_q <= pix_addr_q + PIX_AW'(1);
        end
        DRAIN: begin
          drain_q <= drain_q + DR_W'(1);
          if (drain_q == DR_W'(PIPE_LAT-1)) state_q <= CMP;
        end
        CMP: begin
          if (cls_q == '0 || $signed(acc) > best_q) begin
            best_q     <= $signed(acc);
            best_cls_q <= cls_q;
          end
          if (cls_q == CLS_W'(N_CLASSES-1)) begin
            state_q <= DONE;
          end else begin
            state_q    <= ISSUE;
            cls_q      <= cls_q + CLS_W'(1);
            p_q        <= '0;
            pix_addr_q <= '0;
            wgt_addr_q <= wgt_addr_q + WGT_AW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          ans_q   <= best_cls_q;
          score_q <= best_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pix_addr = pix_addr_q;
  assign wgt_addr = wgt_addr_q;
  assign ans      = ans_q;
  assign score    = score_q;

endmodule

// File: tb/tb_char_classifier.sv
// Directed bench for char_classifier with a queue of model-predicted results.
// A second narrow instance covers the accumulator overflow (wrap or ACC_SATURATE_EN).
module tb_char_classifier;

  typedef struct { int ans; longint score; } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic        busy, done, busy2, done2;
  logic [1:0]  pix_addr, pix_addr2;
  logic [3:0]  wgt_addr, wgt_addr2;
  logic [7:0]  pix_data;
  logic [15:0] wgt_data;
  logic [7:0]  wgt_data2;
  logic [1:0]  ans;
  logic [0:0]  ans2;
  logic [31:0] score;
  logic [15:0] score2;

  logic [7:0]  pix_mem [4];
  logic [15:0] wgt_mem [16];
  exp_t        sb [$];
  int          checks = 0, failures = 0;

`ifdef ACC_SATURATE_EN
  localparam longint SAT_EXP = 32767;
`else
  localparam longint SAT_EXP = -1532;
`endif

  always #5 clk = ~clk;

  char_classifier #(.N_PIXELS(4), .N_CLASSES(3), .WEIGHT_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .done(done), .ans(ans), .score(score)
  );

  char_classifier #(.N_PIXELS(4), .N_CLASSES(2), .WEIGHT_W(8), .ACC_W(16)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2),
    .pix_addr(pix_addr2), .pix_data(8'd255),
    .wgt_addr(wgt_addr2), .wgt_data(wgt_data2),
    .done(done2), .ans(ans2), .score(score2)
  );

  // registered-read RAM models
  always @(posedge clk) begin
    pix_data  <= pix_mem[pix_addr];
    wgt_data  <= wgt_mem[wgt_addr];
    wgt_data2 <= (wgt_addr2 == 4'd4 || wgt_addr2 == 4'd9) ? 8'd0 : 8'd127;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_class(input int c, input int w0, input int w1, input int w2,
                           input int w3, input int b);
    wgt_mem[c*5+0] = 16'(w0);
    wgt_mem[c*5+1] = 16'(w1);
    wgt_mem[c*5+2] = 16'(w2);
    wgt_mem[c*5+3] = 16'(w3);
    wgt_mem[c*5+4] = 16'(b);
  endtask

  function automatic exp_t model();
    exp_t   r;
    longint s;
    r.ans = 0; r.score = 0;
    for (int c = 0; c < 3; c++) begin
      s = longint'($signed(wgt_mem[c*5+4]));
      for (int p = 0; p < 4; p++)
        s += longint'(pix_mem[p]) * longint'($signed(wgt_mem[c*5+p]));
      s = longint'(int'(s));
      if (c == 0 || s > r.score) begin r.ans = c; r.score = s; end
    end
    return r;
  endfunction

  // One run: extra start pulses are sampled at edges xa/xb after acceptance,
  // and a start is always held during the done cycle to check it is dropped.
  task automatic run_case(input string tag, input int xa, input int xb);
    exp_t e;
    int   cyc;
    bit   seen;
    sb.push_back(model());
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      start = (cyc + 1 == xa) || (cyc + 1 == xb);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk({tag, "_busy"}, busy, 1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, cyc, 28);
    e = sb.pop_front();
    chk({tag, "_ans"}, ans, e.ans);
    chk({tag, "_score"}, $signed(score), e.score);
    chk({tag, "_busy_end"}, busy, 0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_pulse"}, done, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk({tag, "_no_rerun"}, seen, 0);
    chk({tag, "_ans_hold"}, ans, e.ans);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 16; i++) wgt_mem[i] = '0;
    for (int i = 0; i < 4; i++) pix_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ans", ans, 0);
    chk("rst_score", score, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_wgt_addr", wgt_addr, 0);

    // accumulator overflow on the narrow instance; both classes tie
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("sat_done_cyc", cyc, 19);
    chk("sat_ans", ans2, 0);
    chk("sat_score", $signed(score2), SAT_EXP);

    for (int i = 0; i < 4; i++) pix_mem[i] = 8'(i + 1);
    set_class(0, 1, 1, 1, 1, 0);
    set_class(1, 0, 0, 0, 1, 5);
    set_class(2, -1, -1, -1, -1, 0);
    run_case("basic", -1, -1);
    chk("basic_const_ans", ans, 0);
    chk("basic_const_score", score, 10);

    set_class(0, 1, 1, 1, 1, -3);
    set_class(1, 0, 0, 0, 1, 3);
    set_class(2, 0, 0, 0, 0, 3);
    run_case("tie", -1, -1);

    set_class(0, -2, -2, -2, -2, 0);
    set_class(1, 0, 0, 0, 0, -3);
    set_class(2, -1, -1, -1, -1, 1);
    run_case("neg", -1, -1);
    chk("neg_const_score", $signed(score), -3);

    // abort mid-run: rst sampled at edge 12 after acceptance
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ans", ans, 0);
    chk("abort_score", score, 0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("abort_no_done", seen, 0);

    for (int i = 0; i < 4; i++) pix_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 15; i++) wgt_mem[i] = 16'($urandom_range(0, 65535));
    run_case("rand", -1, -1);

    set_class(0, 1, 1, 1, 1, 0);
    set_class(1, 0, 0, 0, 1, 5);
    set_class(2, -1, -1, -1, -1, 0);
    for (int i = 0; i < 4; i++) pix_mem[i] = 8'(i + 1);
    run_case("busy_start", 5, 27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
